id_stage_fwd: RTL and testbench
===============================

Name: id_stage_fwd

Overview:
- Parametrised instruction-decode stage for the 5-stage MIPS pipeline; sits between the IF/ID register and the EX stage.
- Contains the register file, the EX/MEM/WB operand-forwarding network and load-use stall detection.
- Resolves branches and jumps early, in ID.
- Owns the ID/EX pipeline register, which carries a valid bit, bubble insertion and flush.
- Control decode stays external; the pre-decoded control bundle enters on ports.

Parameters:
- XLEN, 32, datapath / PC width in bits (>= 32).
- REG_AW, 5, register index width; register file depth = 2**REG_AW.
- PC_SHIFT, 0, left shift applied to the branch offset (0 = word-addressed PC, 2 = byte-addressed PC).

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  synchronous, active-high reset.
- id_valid  in  1  IF/ID register holds a real instruction.
- instr  in  32  instruction word.
- pc  in  XLEN  PC of the instruction in ID.
- ctl_reg_dst, ctl_ext_op, ctl_beq, ctl_bne, ctl_j, ctl_reg_write, ctl_mem_read, ctl_mem_write  in  1 each  decoded control.
- ctl_alu  in  4  ALU op / b_invert bundle, passed through to EX.
- ex_rd, mem_rd, wb_rd  in  REG_AW each  destination register of EX, MEM and WB.
- ex_rw, mem_rw, wb_rw  in  1 each  register-write enable of EX, MEM and WB.
- ex_load  in  1  instruction in EX is a load.
- ex_alu, mem_data, wb_data  in  XLEN each  forwarding sources; wb_data is also the register-file write data.
- flush  in  1  external kill (exception) of the instruction in ID.
- stall  out  1  hold PC and IF/ID this cycle.
- pc_src  out  1  redirect fetch to br_target.
- br_target  out  XLEN  branch/jump target.
- q_valid, q_bus_a, q_bus_b, q_imm, q_rd, q_ctl  out  1, XLEN, XLEN, XLEN, REG_AW, 8  ID/EX register contents.

Behaviour:
- Source fields: rs = instr[25:21], rt = instr[20:16], rd = instr[15:11], each zero-extended or truncated to REG_AW.
- Register file: read is combinational; write happens on the clock edge when wb_rw and wb_rd != 0.
  - Register 0 always reads 0; writes to it are ignored.
  - RST clears all registers to 0.
- Forwarding, evaluated separately per operand (rs → A, rt → B), in priority order:
  - EX (ex_rw, ex_rd == src, src != 0, !ex_load) → ex_alu;
  - else MEM (mem_rw, match) → mem_data;
  - else WB (wb_rw, match) → wb_data;
  - else regfile.
  - A source of 0 is never forwarded.
- Load-use stall: stall = id_valid & !flush & ex_load & ex_rw & ex_rd != 0 & (ex_rd == rs | ex_rd == rt).
  - Stall is purely combinational.
  - During a stall, pc_src is forced to 0 and q_valid is loaded with 0 (bubble).
- Branch resolution, combinational in ID, using the forwarded operands:
  - eq = (A == B).
  - pc_src = id_valid & !stall & !flush & ((ctl_beq & eq) | (ctl_bne & !eq) | ctl_j).
  - br_target = ctl_j ? {pc[XLEN-1:26], instr[25:0]} : pc + (sext(instr[15:0]) << PC_SHIFT), computed modulo 2**XLEN.
- Immediate: ctl_ext_op selects sign-extension, otherwise zero-extension, of instr[15:0] to XLEN.
- Destination: q_rd = ctl_reg_dst ? rd : rt.
- ID/EX register, rising edge:
  - RST → all q_* = 0.
  - else if stall, flush or !id_valid → q_valid = 0 and q_ctl = 0; data fields may update but are don't-care.
  - else → q_valid = 1 and all fields take their ID values.
- q_ctl packing: {ctl_reg_write, ctl_mem_read, ctl_mem_write, ctl_reg_dst, ctl_alu}.
- Latency: one cycle from ID inputs to q_*. stall, pc_src and br_target have zero latency.
- Simultaneous events:
  - flush overrides stall, so stall is 0 when flush is 1.
  - RST overrides everything.
  - Reset asserted mid-stall: the next cycle shows q_valid = 0 and stall is governed only by current inputs.
- Back-to-back load-use: exactly one bubble per dependency. On the next cycle the load is in MEM and is forwarded from mem_data.

Decomposition:
- Shared package pipe_pkg holds:
  - the FWD_{REG,EX,MEM,WB} select encoding;
  - the q_ctl field bit offsets;
  - default XLEN and REG_AW constants.
- One sub-module, reg_file_p (parametrised XLEN/REG_AW, 2 read ports, 1 write port, synchronous reset).
- Forwarding muxes and stall logic stay inline.

Test Plan:
- Reset then idle: RST=1 for 2 cycles → all q_* = 0, stall = 0, pc_src = 0; read of r5 returns 0.
- WB write then ID read, same cycle: wb_rw=1, wb_rd=5, wb_data=0xDEADBEEF, instr reads rs=5 → q_bus_a = 0xDEADBEEF on the next edge.
- Forward priority: ex_rd = mem_rd = 3, ex_alu = 0x11, mem_data = 0x22, rs = 3 → q_bus_a = 0x11. Repeat with ex_rw = 0 → q_bus_a = 0x22.
- Load-use: ex_load=1, ex_rd=4, ID instr uses rt=4 → stall = 1 for one cycle, q_valid = 0. Next cycle, with mem_data = 0x77 → q_bus_b = 0x77, q_valid = 1.
- beq taken with forwarded operand: pc=0x100, imm=0xFFFE, A forwarded from ex_alu = 9, B = reg 9 → pc_src = 1, br_target = 0xFE. bne with the same operands → pc_src = 0.
- flush and stall together: flush=1 while the load-use condition holds → stall = 0, pc_src = 0, q_valid = 0. Writes to r0 never change reads of r0 (stays 0).

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the MIPS pipeline decode stage: forwarding select
// encoding, ID/EX control-bundle bit positions and default widths.
package pipe_pkg;
   localparam int XLEN_DEF   = 32;
   localparam int REG_AW_DEF = 5;

   typedef enum logic [1:0] {
      FWD_REG = 2'd0,
      FWD_EX  = 2'd1,
      FWD_MEM = 2'd2,
      FWD_WB  = 2'd3
   } fwd_sel_t;

   // q_ctl = {reg_write, mem_read, mem_write, reg_dst, alu[3:0]}
   localparam int CTL_W         = 8;
   localparam int CTL_ALU_LSB   = 0;
   localparam int CTL_ALU_W     = 4;
   localparam int CTL_REG_DST   = 4;
   localparam int CTL_MEM_WRITE = 5;
   localparam int CTL_MEM_READ  = 6;
   localparam int CTL_REG_WRITE = 7;
endpackage

// File: rtl/reg_file_p.sv
// Two-read / one-write register file with combinational reads, synchronous
// clear, and a hard-wired zero register at index 0.
import pipe_pkg::*;

module reg_file_p #(
   parameter int XLEN   = XLEN_DEF,
   parameter int REG_AW = REG_AW_DEF
) (
   input  logic              clk,
   input  logic              srst,
   input  logic [REG_AW-1:0] i_ra_addr,
   input  logic [REG_AW-1:0] i_rb_addr,
   input  logic              i_wr_en,
   input  logic [REG_AW-1:0] i_wr_addr,
   input  logic [XLEN-1:0]   i_wr_data,
   output logic [XLEN-1:0]   o_ra_data,
   output logic [XLEN-1:0]   o_rb_data
);
   localparam int DEPTH = 2 ** REG_AW;

   logic [XLEN-1:0] r_mem [DEPTH];

   always_ff @(posedge clk) begin
      if (srst) begin
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      end else if (i_wr_en && i_wr_addr != '0) begin
         r_mem[i_wr_addr] <= i_wr_data;
      end
   end

   assign o_ra_data = (i_ra_addr == '0) ? '0 : r_mem[i_ra_addr];
   assign o_rb_data = (i_rb_addr == '0) ? '0 : r_mem[i_rb_addr];
endmodule

// File: rtl/id_stage_fwd.sv
// MIPS ID stage: register file, EX/MEM/WB operand forwarding, load-use stall,
// early branch/jump resolution and the ID/EX pipeline register.
import pipe_pkg::*;

module id_stage_fwd #(
   parameter int XLEN     = XLEN_DEF,
   parameter int REG_AW   = REG_AW_DEF,
   parameter int PC_SHIFT = 0
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              id_valid,
   input  logic [31:0]       instr,
   input  logic [XLEN-1:0]   pc,
   input  logic              ctl_reg_dst,
   input  logic              ctl_ext_op,
   input  logic              ctl_beq,
   input  logic              ctl_bne,
   input  logic              ctl_j,
   input  logic              ctl_reg_write,
   input  logic              ctl_mem_read,
   input  logic              ctl_mem_write,
   input  logic [3:0]        ctl_alu,
   input  logic [REG_AW-1:0] ex_rd,
   input  logic [REG_AW-1:0] mem_rd,
   input  logic [REG_AW-1:0] wb_rd,
   input  logic              ex_rw,
   input  logic              mem_rw,
   input  logic              wb_rw,
   input  logic              ex_load,
   input  logic [XLEN-1:0]   ex_alu,
   input  logic [XLEN-1:0]   mem_data,
   input  logic [XLEN-1:0]   wb_data,
   input  logic              flush,
   output logic              stall,
   output logic              pc_src,
   output logic [XLEN-1:0]   br_target,
   output logic              q_valid,
   output logic [XLEN-1:0]   q_bus_a,
   output logic [XLEN-1:0]   q_bus_b,
   output logic [XLEN-1:0]   q_imm,
   output logic [REG_AW-1:0] q_rd,
   output logic [CTL_W-1:0]  q_ctl
);
   logic [REG_AW-1:0] w_src [2];
   logic [REG_AW-1:0] w_rd;
   logic [XLEN-1:0]   w_rf_data [2];
   logic [XLEN-1:0]   w_opnd [2];
   fwd_sel_t          w_fwd_sel [2];
   logic [XLEN-1:0]   w_sext;
   logic [XLEN-1:0]   w_imm;
   logic [CTL_W-1:0]  w_ctl;
   logic              w_eq;
   logic              w_unused_opcode;

   assign w_src[0] = REG_AW'(instr[25:21]);
   assign w_src[1] = REG_AW'(instr[20:16]);
   assign w_rd     = REG_AW'(instr[15:11]);
   assign w_unused_opcode = ^instr[31:26];

   reg_file_p #(.XLEN(XLEN), .REG_AW(REG_AW)) u_rf (
      .clk       (CLK),
      .srst      (RST),
      .i_ra_addr (w_src[0]),
      .i_rb_addr (w_src[1]),
      .i_wr_en   (wb_rw),
      .i_wr_addr (wb_rd),
      .i_wr_data (wb_data),
      .o_ra_data (w_rf_data[0]),
      .o_rb_data (w_rf_data[1])
   );

   // Loads are excluded from EX forwarding: their data does not exist yet,
   // so the stall holds the consumer until the load reaches MEM.
   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
         assign w_fwd_sel[gi] =
            (w_src[gi] == '0)                               ? FWD_REG :
            (ex_rw  && ex_rd  == w_src[gi] && !ex_load)     ? FWD_EX  :
            (mem_rw && mem_rd == w_src[gi])                 ? FWD_MEM :
            (wb_rw  && wb_rd  == w_src[gi])                 ? FWD_WB  : FWD_REG;

         assign w_opnd[gi] =
            (w_fwd_sel[gi] == FWD_EX)  ? ex_alu   :
            (w_fwd_sel[gi] == FWD_MEM) ? mem_data :
            (w_fwd_sel[gi] == FWD_WB)  ? wb_data  : w_rf_data[gi];
      end
   endgenerate

   assign stall = id_valid && !flush && ex_load && ex_rw && (ex_rd != '0) &&
                  ((ex_rd == w_src[0]) || (ex_rd == w_src[1]));

   assign w_eq   = (w_opnd[0] == w_opnd[1]);
   assign pc_src = id_valid && !stall && !flush &&
                   ((ctl_beq && w_eq) || (ctl_bne && !w_eq) || ctl_j);

   assign w_sext    = {{(XLEN-16){instr[15]}}, instr[15:0]};
   assign w_imm     = ctl_ext_op ? w_sext : {{(XLEN-16){1'b0}}, instr[15:0]};
   assign br_target = ctl_j ? {pc[XLEN-1:26], instr[25:0]}
                            : pc + (w_sext << PC_SHIFT);

   always_comb begin
      w_ctl = '0;
      w_ctl[CTL_ALU_LSB +: CTL_ALU_W] = ctl_alu;
      w_ctl[CTL_REG_DST]   = ctl_reg_dst;
      w_ctl[CTL_MEM_WRITE] = ctl_mem_write;
      w_ctl[CTL_MEM_READ]  = ctl_mem_read;
      w_ctl[CTL_REG_WRITE] = ctl_reg_write;
   end

   logic              r_q_valid;
   logic [XLEN-1:0]   r_q_bus_a, r_q_bus_b, r_q_imm;
   logic [REG_AW-1:0] r_q_rd;
   logic [CTL_W-1:0]  r_q_ctl;

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_q_valid <= 1'b0;
         r_q_bus_a <= '0;
         r_q_bus_b <= '0;
         r_q_imm   <= '0;
         r_q_rd    <= '0;
         r_q_ctl   <= '0;
      end else begin
         r_q_bus_a <= w_opnd[0];
         r_q_bus_b <= w_opnd[1];
         r_q_imm   <= w_imm;
         r_q_rd    <= ctl_reg_dst ? w_rd : w_src[1];
         if (stall || flush || !id_valid) begin
            r_q_valid <= 1'b0;
            r_q_ctl   <= '0;
         end else begin
            r_q_valid <= 1'b1;
            r_q_ctl   <= w_ctl;
         end
      end
   end

   assign q_valid = r_q_valid;
   assign q_bus_a = r_q_bus_a;
   assign q_bus_b = r_q_bus_b;
   assign q_imm   = r_q_imm;
   assign q_rd    = r_q_rd;
   assign q_ctl   = r_q_ctl;
endmodule

// File: tb/tb_id_stage_fwd.sv
// Directed bench for id_stage_fwd: reset, regfile write/read, forwarding
// priority, load-use bubbles, branch resolution, flush and r0 behaviour.
module tb_id_stage_fwd;
   logic        CLK = 1'b0;
   logic        RST;
   logic        id_valid;
   logic [31:0] instr, pc;
   logic        ctl_reg_dst, ctl_ext_op, ctl_beq, ctl_bne, ctl_j;
   logic        ctl_reg_write, ctl_mem_read, ctl_mem_write;
   logic [3:0]  ctl_alu;
   logic [4:0]  ex_rd, mem_rd, wb_rd;
   logic        ex_rw, mem_rw, wb_rw, ex_load;
   logic [31:0] ex_alu, mem_data, wb_data;
   logic        flush;
   logic        stall, pc_src, q_valid;
   logic [31:0] br_target, q_bus_a, q_bus_b, q_imm;
   logic [4:0]  q_rd;
   logic [7:0]  q_ctl;

   int n_pass  = 0;
   int n_total = 0;

   always #5 CLK = ~CLK;

   id_stage_fwd dut (
      .CLK(CLK), .RST(RST), .id_valid(id_valid), .instr(instr), .pc(pc),
      .ctl_reg_dst(ctl_reg_dst), .ctl_ext_op(ctl_ext_op), .ctl_beq(ctl_beq),
      .ctl_bne(ctl_bne), .ctl_j(ctl_j), .ctl_reg_write(ctl_reg_write),
      .ctl_mem_read(ctl_mem_read), .ctl_mem_write(ctl_mem_write), .ctl_alu(ctl_alu),
      .ex_rd(ex_rd), .mem_rd(mem_rd), .wb_rd(wb_rd), .ex_rw(ex_rw), .mem_rw(mem_rw),
      .wb_rw(wb_rw), .ex_load(ex_load), .ex_alu(ex_alu), .mem_data(mem_data),
      .wb_data(wb_data), .flush(flush), .stall(stall), .pc_src(pc_src),
      .br_target(br_target), .q_valid(q_valid), .q_bus_a(q_bus_a), .q_bus_b(q_bus_b),
      .q_imm(q_imm), .q_rd(q_rd), .q_ctl(q_ctl)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rs,
                                      input logic [4:0] rt, input logic [15:0] imm);
      return {op, rs, rt, imm};
   endfunction

   task automatic idle();
      id_valid = 0; instr = 0; pc = 0;
      ctl_reg_dst = 0; ctl_ext_op = 0; ctl_beq = 0; ctl_bne = 0; ctl_j = 0;
      ctl_reg_write = 0; ctl_mem_read = 0; ctl_mem_write = 0; ctl_alu = 0;
      ex_rd = 0; mem_rd = 0; wb_rd = 0; ex_rw = 0; mem_rw = 0; wb_rw = 0;
      ex_load = 0; ex_alu = 0; mem_data = 0; wb_data = 0; flush = 0;
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   initial begin
      idle();
      RST = 1;
      tick(); tick();
      chk("rst_q_valid", q_valid, 0);
      chk("rst_q_bus_a", q_bus_a, 0);
      chk("rst_q_bus_b", q_bus_b, 0);
      chk("rst_q_imm",   q_imm,   0);
      chk("rst_q_rd",    q_rd,    0);
      chk("rst_q_ctl",   q_ctl,   0);
      chk("rst_stall",   stall,   0);
      chk("rst_pc_src",  pc_src,  0);

      // r5 reads 0 after reset
      RST = 0; id_valid = 1; instr = mk(6'h0, 5'd5, 5'd0, 16'h0);
      tick();
      chk("r5_after_rst", q_bus_a, 0);
      chk("r5_q_valid", q_valid, 1);

      // WB write bypassed into same-cycle read, then read from regfile
      wb_rw = 1; wb_rd = 5; wb_data = 32'hDEADBEEF;
      tick();
      chk("wb_bypass_a", q_bus_a, 32'hDEADBEEF);
      wb_rw = 0; wb_data = 0;
      tick();
      chk("rf_read_a", q_bus_a, 32'hDEADBEEF);

      // EX beats MEM; control packing, rd select, zero-extended imm
      instr = mk(6'h0, 5'd3, 5'd0, {5'd7, 11'h0});
      ctl_reg_write = 1; ctl_reg_dst = 1; ctl_alu = 4'b0110;
      ex_rw = 1; ex_rd = 3; ex_alu = 32'h11;
      mem_rw = 1; mem_rd = 3; mem_data = 32'h22;
      tick();
      chk("fwd_ex_prio", q_bus_a, 32'h11);
      chk("ctl_pack", q_ctl, 8'h96);
      chk("rd_sel_rd", q_rd, 7);
      chk("imm_zext", q_imm, 32'h0000_3800);
      ex_rw = 0;
      tick();
      chk("fwd_mem", q_bus_a, 32'h22);
      // EX load to same reg is not forwarded (falls to MEM) on rs=3 path
      ex_rw = 1; ex_load = 1; ex_rd = 3; ctl_reg_dst = 0;
      #1;
      chk("ld_stall_rs", stall, 1);
      idle(); id_valid = 1;

      // Source 0 never forwarded
      ex_rw = 1; ex_rd = 0; ex_alu = 32'h55; instr = mk(6'h0, 5'd0, 5'd0, 16'h0);
      tick();
      chk("src0_no_fwd", q_bus_a, 0);

      // Load-use on rt: one bubble, then MEM forward
      ex_rw = 1; ex_load = 1; ex_rd = 4; ex_alu = 32'hBAD;
      instr = mk(6'h0, 5'd0, 5'd4, 16'h0); ctl_j = 1; ctl_reg_write = 1;
      #1;
      chk("lu_stall", stall, 1);
      chk("lu_pc_src", pc_src, 0);
      tick();
      chk("lu_bubble_v", q_valid, 0);
      chk("lu_bubble_ctl", q_ctl, 0);
      ex_rw = 0; ex_load = 0; ex_rd = 0; ctl_j = 0; ctl_reg_write = 0;
      ctl_mem_read = 1; ctl_mem_write = 1;
      mem_rw = 1; mem_rd = 4; mem_data = 32'h77;
      #1;
      chk("lu_release", stall, 0);
      tick();
      chk("lu_mem_fwd_b", q_bus_b, 32'h77);
      chk("lu_valid", q_valid, 1);
      chk("lu_ctl", q_ctl, 8'h60);
      chk("rd_sel_rt", q_rd, 4);
      idle(); id_valid = 1;

      // Load with ex_rd = 0 must not stall
      ex_rw = 1; ex_load = 1; ex_rd = 0;
      #1;
      chk("ld_rd0_nostall", stall, 0);
      idle(); id_valid = 1;

      // Put 9 in r9
      wb_rw = 1; wb_rd = 9; wb_data = 9;
      tick();
      idle(); id_valid = 1;

      // beq taken with A forwarded from EX
      pc = 32'h100; instr = mk(6'h04, 5'd8, 5'd9, 16'hFFFE);
      ctl_beq = 1; ctl_ext_op = 1;
      ex_rw = 1; ex_rd = 8; ex_alu = 9;
      #1;
      chk("beq_pc_src", pc_src, 1);
      chk("beq_target", br_target, 32'h0000_00FE);
      ctl_beq = 0; ctl_bne = 1;
      #1;
      chk("bne_eq_not_taken", pc_src, 0);
      ex_rw = 0;
      #1;
      chk("bne_ne_taken", pc_src, 1);
      tick();
      chk("imm_sext", q_imm, 32'hFFFF_FFFE);
      chk("rf_r9", q_bus_b, 9);
      ctl_bne = 0; ctl_j = 1; pc = 32'hF000_0100; instr = {6'h02, 26'h000_0040};
      #1;
      chk("j_pc_src", pc_src, 1);
      chk("j_target", br_target, 32'hF000_0040);
      idle(); id_valid = 1;

      // flush with load-use pending: no stall, no redirect, bubble
      ex_rw = 1; ex_load = 1; ex_rd = 4; instr = mk(6'h0, 5'd0, 5'd4, 16'h0);
      ctl_j = 1; flush = 1;
      #1;
      chk("flush_stall", stall, 0);
      chk("flush_pc_src", pc_src, 0);
      tick();
      chk("flush_q_valid", q_valid, 0);
      idle(); id_valid = 1;

      // Writes to r0 are ignored
      wb_rw = 1; wb_rd = 0; wb_data = 32'hFFFF; instr = mk(6'h0, 5'd0, 5'd0, 16'h0);
      tick();
      chk("r0_wb_cycle", q_bus_a, 0);
      wb_rw = 0;
      tick();
      chk("r0_after_wr", q_bus_a, 0);

      // Reset mid-stall clears pipe register and regfile
      instr = mk(6'h0, 5'd9, 5'd4, 16'h0); ex_rw = 1; ex_load = 1; ex_rd = 4; RST = 1;
      tick();
      chk("rst_mid_q_valid", q_valid, 0);
      chk("rst_mid_q_bus_b", q_bus_b, 0);
      RST = 0; idle(); id_valid = 1; instr = mk(6'h0, 5'd9, 5'd0, 16'h0);
      tick();
      chk("rf_cleared_r9", q_bus_a, 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
